// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for one convolution layer: load IFM/weights, compute, write, advance.
// Optional busy-cycle counter enabled by defining SCHED_PERF_CNT_EN.
module conv_tile_scheduler #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned IFM_SIZE      = 34,
  parameter int unsigned IFM_CHANNEL   = 3,
  parameter int unsigned OFM_CHANNEL   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ifm_load,
  input  logic        ifm_done,
  output logic        wgt_load,
  input  logic        wgt_done,
  output logic        compute_en,
  output logic        wr_start,
  input  logic        wr_done,
  output logic [8:0]  tile_row,
  output logic [8:0]  tile_col,
  output logic [7:0]  filter_grp,
  output logic        busy,
  output logic        done,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned OFM_SIZE       = IFM_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned NUM_COL        = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned NUM_GRP        = (OFM_CHANNEL + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned COMPUTE_CYCLES = IFM_CHANNEL * KERNEL_SIZE * KERNEL_SIZE
                                           + 2 * SYSTOLIC_SIZE - 1;
  localparam int unsigned CW             = $clog2(COMPUTE_CYCLES + 1);

  localparam logic [8:0]    ROW_LAST = 9'(OFM_SIZE - 1);
  localparam logic [8:0]    COL_LAST = 9'(NUM_COL - 1);
  localparam logic [7:0]    GRP_LAST = 8'(NUM_GRP - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(COMPUTE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_LOAD, COMPUTE, WRITE, WAIT_WR, ADVANCE, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    row_q, row_d, col_q, col_d;
  logic [7:0]    grp_q, grp_d;
  logic          ifm_flag_q, ifm_flag_d, wgt_flag_q, wgt_flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_tile, row_last, col_last, grp_last;

  assign first_tile = (row_q == '0) && (col_q == '0);
  assign row_last   = (row_q == ROW_LAST);
  assign col_last   = (col_q == COL_LAST);
  assign grp_last   = (grp_q == GRP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      grp_q      <= '0;
      ifm_flag_q <= 1'b0;
      wgt_flag_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      grp_q      <= grp_d;
      ifm_flag_q <= ifm_flag_d;
      wgt_flag_q <= wgt_flag_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    grp_d      = grp_q;
    ifm_flag_d = 1'b0;
    wgt_flag_d = 1'b0;
    cnt_d      = cnt_q;
    ifm_load   = 1'b0;
    wgt_load   = 1'b0;
    compute_en = 1'b0;
    wr_start   = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          grp_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Done pulses coincident with the load pulse are captured here.
        ifm_load   = 1'b1;
        wgt_load   = first_tile;
        ifm_flag_d = ifm_done;
        wgt_flag_d = first_tile ? wgt_done : 1'b1;
        state_d    = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        ifm_flag_d = ifm_flag_q | ifm_done;
        wgt_flag_d = wgt_flag_q | wgt_done;
        if (ifm_flag_d && wgt_flag_d) begin
          ifm_flag_d = 1'b0;
          wgt_flag_d = 1'b0;
          cnt_d      = CNT_INIT;
          state_d    = COMPUTE;
        end
      end
      COMPUTE: begin
        compute_en = 1'b1;
        if (cnt_q == '0) state_d = WRITE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WRITE: begin
        wr_start = 1'b1;
        state_d  = WAIT_WR;
      end
      WAIT_WR: begin
        if (wr_done) state_d = ADVANCE;
      end
      ADVANCE: begin
        row_d = row_last ? '0 : row_q + 1'b1;
        if (row_last) col_d = col_last ? '0 : col_q + 1'b1;
        if (row_last && col_last) grp_d = grp_last ? '0 : grp_q + 1'b1;
        state_d = (row_last && col_last && grp_last) ? FINISH : LOAD;
      end
      FINISH: begin
        done    = 1'b1;
        row_d   = '0;
        col_d   = '0;
        grp_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign tile_row   = row_q;
  assign tile_col   = col_q;
  assign filter_grp = grp_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cyc_q <= '0;
    else if (state_q == IDLE) begin
      if (start)                     cyc_q <= '0;
    end else if (cyc_q != '1)        cyc_q <= cyc_q + 1'b1;
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler on a 4x4 array, 6x6 IFM, 3x3 kernel, 8 filters.
module tb_conv_tile_scheduler;

  localparam int OFM = 4;
  localparam int CC  = 16;
  localparam int NT  = 8;

  logic        clk = 1'b0;
  logic        rst, start, ifm_done, wgt_done, wr_done;
  logic        ifm_load, wgt_load, compute_en, wr_start, busy, done;
  logic [8:0]  tile_row, tile_col;
  logic [7:0]  filter_grp;
  logic [31:0] cycle_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_ifm = 0, n_wgt = 0, n_wr = 0, n_done = 0;
  int exp_busy;

  always #5 clk = ~clk;

  conv_tile_scheduler #(
    .SYSTOLIC_SIZE(4), .KERNEL_SIZE(3), .IFM_SIZE(6), .IFM_CHANNEL(1), .OFM_CHANNEL(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ifm_load(ifm_load), .ifm_done(ifm_done),
    .wgt_load(wgt_load), .wgt_done(wgt_done),
    .compute_en(compute_en), .wr_start(wr_start), .wr_done(wr_done),
    .tile_row(tile_row), .tile_col(tile_col), .filter_grp(filter_grp),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  always @(negedge clk) begin
    if (ifm_load) n_ifm++;
    if (wgt_load) n_wgt++;
    if (wr_start) n_wr++;
    if (done)     n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int b);
`ifdef SCHED_PERF_CNT_EN
    return 32'(b);
`else
    return 32'd0;
`endif
  endfunction

  // Called on the negedge where LOAD is expected. Loader pulses arrive di/dw cycles
  // after LOAD (wgt only on a group's first tile), writer pulse dwr cycles after WRITE.
  task automatic run_tile(input int t, input int di, input int dw, input int dwr,
                          input bit inject, input bit abort);
    int  r, g, dmax, tc, n;
    bit  first;
    r     = t % OFM;
    g     = t / OFM;
    first = (r == 0);
    dmax  = (first && dw > di) ? dw : di;
    tc    = ((dmax < 1) ? 1 : dmax) + 1;
    check($sformatf("t%0d_ifm_load", t), 32'(ifm_load), 1);
    check($sformatf("t%0d_wgt_load", t), 32'(wgt_load), 32'(first));
    check($sformatf("t%0d_idx", t), {6'd0, tile_row, tile_col, filter_grp},
          {6'd0, 9'(r), 9'd0, 8'(g)});
    for (int k = 0; k < tc; k++) begin
      if (k == tc - 1) check($sformatf("t%0d_cen_pre", t), 32'(compute_en), 0);
      ifm_done = (k == di);
      wgt_done = first && (k == dw);
      @(negedge clk);
    end
    ifm_done = 1'b0;
    wgt_done = 1'b0;
    check($sformatf("t%0d_cen_start", t), 32'(compute_en), 1);
    n = 0;
    while (compute_en && n < 40) begin
      n++;
      if (inject && n == 5) begin
        start = 1'b1; wr_done = 1'b1; ifm_done = 1'b1; wgt_done = 1'b1;
      end else begin
        start = 1'b0; wr_done = 1'b0; ifm_done = 1'b0; wgt_done = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; wr_done = 1'b0; ifm_done = 1'b0; wgt_done = 1'b0;
    check($sformatf("t%0d_cen_len", t), 32'(n), CC);
    check($sformatf("t%0d_wr_start", t), 32'(wr_start), 1);
    @(negedge clk);
    if (abort) begin
      #2 rst = 1'b1;
      #1;
      check("abort_ctl", {26'd0, ifm_load, wgt_load, compute_en, wr_start, busy, done}, 0);
      check("abort_idx", {6'd0, tile_row, tile_col, filter_grp}, 0);
      return;
    end
    repeat (dwr - 1) @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    @(negedge clk);
    exp_busy += tc + CC + 1 + dwr + 1;
    if (t == NT - 1) begin
      exp_busy += 1;
      check("finish_done", 32'(done), 1);
      check("finish_idx", {6'd0, tile_row, tile_col, filter_grp}, 0);
      @(negedge clk);
      check("after_done", {30'd0, busy, done}, 0);
    end
  endtask

  initial begin
    int b_ifm, b_wgt, b_wr, b_done;
    rst = 1'b1; start = 1'b0; ifm_done = 1'b0; wgt_done = 1'b0; wr_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {26'd0, ifm_load, wgt_load, compute_en, wr_start, busy, done}, 0);
    check("rst_idx", {6'd0, tile_row, tile_col, filter_grp}, 0);
    check("rst_cnt", cycle_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Run A: 3-cycle latencies, with same-cycle, staggered and in-LOAD arrivals plus stray pulses.
    b_ifm = n_ifm; b_wgt = n_wgt; b_wr = n_wr; b_done = n_done;
    exp_busy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < NT; t++) begin
      case (t)
        2:       run_tile(t, 3, 3, 3, 1'b1, 1'b0);
        4:       run_tile(t, 1, 6, 3, 1'b0, 1'b0);
        5:       run_tile(t, 0, 0, 3, 1'b0, 1'b0);
        default: run_tile(t, 3, 3, 3, 1'b0, 1'b0);
      endcase
    end
    repeat (3) @(negedge clk);
    check("A_n_ifm", 32'(n_ifm - b_ifm), 8);
    check("A_n_wgt", 32'(n_wgt - b_wgt), 2);
    check("A_n_wr", 32'(n_wr - b_wr), 8);
    check("A_n_done", 32'(n_done - b_done), 1);
    check("A_cycle_cnt", cycle_cnt, exp_cnt(exp_busy));

    // Run B: reset while waiting for the write of tile 3.
    b_done = n_done;
    exp_busy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3; t++) run_tile(t, 2, 2, 2, 1'b0, 1'b0);
    run_tile(3, 2, 2, 2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("B_no_done", 32'(n_done - b_done), 0);
    check("B_busy", 32'(busy), 0);
    check("B_cycle_cnt", cycle_cnt, 0);

    // Run C: restart from the origin with fixed 2-cycle latencies.
    b_ifm = n_ifm; b_wgt = n_wgt; b_wr = n_wr; b_done = n_done;
    exp_busy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < NT; t++) run_tile(t, 2, 2, 2, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("C_n_ifm", 32'(n_ifm - b_ifm), 8);
    check("C_n_wgt", 32'(n_wgt - b_wgt), 2);
    check("C_n_done", 32'(n_done - b_done), 1);
    check("C_cycle_cnt", cycle_cnt, exp_cnt(exp_busy));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
